// File: rtl/b1_mem_arbiter_if.sv
// b1 RAM arbiter bus: two requester ports plus the single-port bram side.
// slave = arbiter view, master = requesters/RAM environment view.
interface b1_mem_arbiter_if #(
    parameter int RAM_ADDR_WIDTH = 13
);
    logic                      p0_req;
    logic                      p1_req;
    logic                      p0_we;
    logic                      p1_we;
    logic [15:0]               p0_addr;
    logic [15:0]               p1_addr;
    logic [7:0]                p0_wdata;
    logic [7:0]                p1_wdata;
    logic                      p0_gnt;
    logic                      p1_gnt;
    logic                      p0_rvalid;
    logic                      p1_rvalid;
    logic                      p0_err;
    logic                      p1_err;
    logic [7:0]                rdata;
    logic [RAM_ADDR_WIDTH-1:0] mem_addr;
    logic                      mem_cs_n;
    logic                      mem_wr_n;
    logic                      mem_rd_n;
    logic [7:0]                mem_wdata;
    logic [7:0]                mem_rdata;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we,
        input  p0_addr, p1_addr, p0_wdata, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
        output p0_err, p1_err, rdata,
        output mem_addr, mem_cs_n, mem_wr_n, mem_rd_n,
        output mem_wdata
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we,
        output p0_addr, p1_addr, p0_wdata, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
        input  p0_err, p1_err, rdata,
        input  mem_addr, mem_cs_n, mem_wr_n, mem_rd_n,
        input  mem_wdata
    );
endinterface

// File: rtl/b1_mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port b1 bram (CPU port 0, UART loader port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 1 wins ties.
module b1_mem_arbiter #(
    parameter int RAM_ADDR_WIDTH = 13
) (
    input  logic              CLK,
    input  logic              reset_n,
    b1_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA
    } state_t;

    state_t state_q, state_d;

    logic sel_q, sel_d;
    logic we_q, we_d;
    logic oor_q, oor_d;
    logic win;
    logic [15:0] addr_d;
    logic [7:0]  rd_val;

    logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic err0_q, err0_d, err1_q, err1_d;
    logic rv0_q, rv0_d, rv1_q, rv1_d;
    logic cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
    logic [RAM_ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [7:0] mwdata_q, mwdata_d;
    logic [7:0] rdata_q, rdata_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_p1_q, last_p1_d;
`endif

    // The bram output is already registered, so it is muxed straight out during RDATA.
    assign rd_val = oor_q ? 8'hFF : bus.mem_rdata;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        oor_d    = oor_q;
        win      = 1'b0;
        addr_d   = 16'h0000;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rv0_d    = 1'b0;
        rv1_d    = 1'b0;
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        rdata_d  = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_p1_d = last_p1_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win = (bus.p0_req && bus.p1_req) ? ~last_p1_q : bus.p1_req;
                    last_p1_d = win;
`else
                    win = bus.p1_req;
`endif
                    sel_d    = win;
                    we_d     = win ? bus.p1_we : bus.p0_we;
                    addr_d   = win ? bus.p1_addr : bus.p0_addr;
                    mwdata_d = win ? bus.p1_wdata : bus.p0_wdata;
                    maddr_d  = addr_d[RAM_ADDR_WIDTH-1:0];
                    oor_d    = |addr_d[15:RAM_ADDR_WIDTH];
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                    err0_d   = ~win & oor_d;
                    err1_d   = win & oor_d;
                    if (!oor_d) begin
                        cs_n_d = 1'b0;
                        wr_n_d = ~we_d;
                        rd_n_d = we_d;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    rv0_d   = ~sel_q;
                    rv1_d   = sel_q;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                rdata_d = rd_val;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            oor_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            maddr_q  <= '0;
            mwdata_q <= 8'h00;
            rdata_q  <= 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
            last_p1_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            oor_q    <= oor_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
            rd_n_q   <= rd_n_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_p1_q <= last_p1_d;
`endif
        end
    end

    assign bus.p0_gnt    = gnt0_q;
    assign bus.p1_gnt    = gnt1_q;
    assign bus.p0_err    = err0_q;
    assign bus.p1_err    = err1_q;
    assign bus.p0_rvalid = rv0_q;
    assign bus.p1_rvalid = rv1_q;
    assign bus.mem_cs_n  = cs_n_q;
    assign bus.mem_wr_n  = wr_n_q;
    assign bus.mem_rd_n  = rd_n_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mwdata_q;
    assign bus.rdata     = (state_q == RDATA) ? rd_val : rdata_q;
endmodule

// File: tb/tb_b1_mem_arbiter.sv
// Directed bench for b1_mem_arbiter with a behavioural 1-cycle registered bram.
// Tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_b1_mem_arbiter;
    logic CLK = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] ram [0:8191];

    b1_mem_arbiter_if #(.RAM_ADDR_WIDTH(13)) bus ();

    b1_mem_arbiter #(.RAM_ADDR_WIDTH(13)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!bus.mem_cs_n) begin
            if (!bus.mem_wr_n) ram[bus.mem_addr] <= bus.mem_wdata;
            if (!bus.mem_rd_n) bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_outs(input string tag);
        check({tag, "_gnt"}, {bus.p0_gnt, bus.p1_gnt}, 0);
        check({tag, "_rv"}, {bus.p0_rvalid, bus.p1_rvalid}, 0);
        check({tag, "_strb"}, {bus.mem_cs_n, bus.mem_wr_n, bus.mem_rd_n}, 3'b111);
    endtask

    initial begin
        logic exp_win;
        for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
        ram[13'h0200] = 8'hA5;
        ram[13'h1FFF] = 8'h5A;
        bus.mem_rdata = 8'h00;
        bus.p0_req = 0; bus.p1_req = 0;
        bus.p0_we = 0;  bus.p1_we = 0;
        bus.p0_addr = 0; bus.p1_addr = 0;
        bus.p0_wdata = 0; bus.p1_wdata = 0;

        // reset state
        tick(); tick();
        idle_outs("rst");
        check("rst_err", {bus.p0_err, bus.p1_err}, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_rdata", bus.rdata, 0);
        reset_n = 1;

        // port 0 read of 0x0200
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 16'h0200;
        tick();
        check("rd_gnt", {bus.p0_gnt, bus.p1_gnt}, 2'b10);
        check("rd_strb", {bus.mem_cs_n, bus.mem_wr_n, bus.mem_rd_n}, 3'b010);
        check("rd_addr", bus.mem_addr, 16'h0200);
        check("rd_err", bus.p0_err, 0);
        bus.p0_req = 0;
        tick();
        check("rd_rv", {bus.p0_rvalid, bus.p1_rvalid}, 2'b10);
        check("rd_data", bus.rdata, 8'hA5);
        check("rd_strb_hi", {bus.mem_cs_n, bus.mem_wr_n, bus.mem_rd_n}, 3'b111);
        tick();
        idle_outs("rd_end");
        check("rd_hold", bus.rdata, 8'hA5);

        // port 1 write 0x0010 = 0x41, then port 0 reads it back
        bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 16'h0010; bus.p1_wdata = 8'h41;
        tick();
        check("wr_gnt", {bus.p0_gnt, bus.p1_gnt}, 2'b01);
        check("wr_strb", {bus.mem_cs_n, bus.mem_wr_n, bus.mem_rd_n}, 3'b001);
        check("wr_wdata", bus.mem_wdata, 8'h41);
        bus.p1_req = 0;
        tick();
        idle_outs("wr_one");
        check("wr_ram", ram[13'h0010], 8'h41);
        bus.p0_req = 1; bus.p0_addr = 16'h0010;
        tick();
        check("rb_gnt", bus.p0_gnt, 1);
        bus.p0_req = 0;
        tick();
        check("rb_rv", bus.p0_rvalid, 1);
        check("rb_data", bus.rdata, 8'h41);
        tick();

        // ties from a fresh reset, both ports writing continuously
        reset_n = 0;
        tick();
        reset_n = 1;
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 16'h0020; bus.p0_wdata = 8'h11;
        bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 16'h0030; bus.p1_wdata = 8'h22;
        tick();
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_win = (k % 2 == 1);
`else
            exp_win = 1'b1;
`endif
            check($sformatf("tie%0d", k), {bus.p0_gnt, bus.p1_gnt},
                  {~exp_win, exp_win});
            tick();
            if (k < 3) tick();
        end
        bus.p1_req = 0;
        tick();
        check("tie_p0", {bus.p0_gnt, bus.p1_gnt}, 2'b10);
        bus.p0_req = 0;
        tick(); tick();
        check("tie_ram0", ram[13'h0020], 8'h11);
        check("tie_ram1", ram[13'h0030], 8'h22);

        // out-of-range read and write
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 16'h2000;
        tick();
        check("oor_gnt", {bus.p0_gnt, bus.p0_err, bus.p1_err}, 3'b110);
        check("oor_strb", {bus.mem_cs_n, bus.mem_wr_n, bus.mem_rd_n}, 3'b111);
        bus.p0_req = 0;
        tick();
        check("oor_rv", bus.p0_rvalid, 1);
        check("oor_data", bus.rdata, 8'hFF);
        tick();
        bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 16'hFFFF; bus.p1_wdata = 8'h77;
        tick();
        check("oorw_gnt", {bus.p1_gnt, bus.p1_err, bus.p0_err}, 3'b110);
        check("oorw_strb", {bus.mem_cs_n, bus.mem_wr_n, bus.mem_rd_n}, 3'b111);
        bus.p1_req = 0;
        tick();
        check("oorw_rv", bus.p1_rvalid, 0);
        check("oorw_ram", ram[13'h1FFF], 8'h5A);

        // reset during the ACCESS cycle of a read
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 16'h0200;
        tick();
        check("mr_gnt", bus.p0_gnt, 1);
        bus.p0_req = 0;
        reset_n = 0;
        tick();
        idle_outs("mr_rst");
        reset_n = 1;
        tick();
        idle_outs("mr_after");
        bus.p0_req = 1; bus.p0_addr = 16'h0010;
        tick();
        check("mr2_gnt", bus.p0_gnt, 1);
        bus.p0_req = 0;
        tick();
        check("mr2_rv", bus.p0_rvalid, 1);
        check("mr2_data", bus.rdata, 8'h41);
        tick();

        // port 0 holds req for 3 cycles after gnt
        bus.p0_req = 1; bus.p0_addr = 16'h0200;
        tick();
        check("hold_g1", bus.p0_gnt, 1);
        tick();
        check("hold_c2", {bus.p0_gnt, bus.p0_rvalid}, 2'b01);
        tick();
        check("hold_c3", {bus.p0_gnt, bus.p0_rvalid}, 2'b00);
        tick();
        check("hold_g2", bus.p0_gnt, 1);
        bus.p0_req = 0;
        tick();
        check("hold_c5", {bus.p0_gnt, bus.p0_rvalid}, 2'b01);
        check("hold_data", bus.rdata, 8'hA5);
        tick();
        check("hold_c6", bus.p0_gnt, 0);
        tick();
        check("hold_c7", bus.p0_gnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
